charlieplex_scan: RTL

- Scan controller for the 7-pin charlieplexed LED array (7×6 = 42 LEDs) driven through tristate I/O cells.
- Holds a 42-entry × 4-bit brightness framebuffer, written over a Wishbone classic slave port.
- Sequences one anode pin at a time with 4-bit PWM per LED and a blanking tick between rows.
- Produces the per-pin output-enable and output-data vectors that feed the charlieplex I/O buffers.

---
 rtl/charlieplex_scan.sv | 132 +++++++++++++
 1 files changed

// File: rtl/charlieplex_scan.sv
// Charlieplex scan controller: 42-pixel 4-bit PWM framebuffer behind a Wishbone
// classic slave, driving one anode row at a time onto 7 tristate pins.
module charlieplex_scan #(
   parameter int unsigned TICK_DIV = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       wb_cyc_i,
   input  logic       wb_stb_i,
   input  logic       wb_we_i,
   input  logic [5:0] wb_adr_i,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   output logic       wb_ack_o,
   output logic [6:0] charlieplex_en_o,
   output logic [6:0] charlieplex_o
);

   localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic {BLANK, DRIVE} state_t;

   state_t        state_q, state_d;
   logic [2:0]    row_q, row_d;
   logic [3:0]    pwm_q, pwm_d;
   logic [PW-1:0] presc_q;
   logic          tick;
   logic [3:0]    fb_q [42];
   logic          enable_q;
   logic          wb_req;
   logic [7:0]    rd_data;
   logic [6:0]    en_d, out_d;
   logic [2:0]    pin, col;
   logic [5:0]    idx;
   logic          unused_dat;

   assign unused_dat = ^wb_dat_i[7:4];

   assign tick = (presc_q == PRESC_MAX);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     presc_q <= '0;
      else if (tick) presc_q <= '0;
      else           presc_q <= presc_q + 1'b1;
   end

   assign wb_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;

   always_comb begin
      rd_data = '0;
      if (wb_adr_i < 6'd42)       rd_data = {4'b0, fb_q[wb_adr_i]};
      else if (wb_adr_i == 6'd63) rd_data = {7'b0, enable_q};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fb_q     <= '{default: '0};
         enable_q <= 1'b0;
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= wb_req;
         if (wb_req) begin
            wb_dat_o <= rd_data;
            if (wb_we_i) begin
               if (wb_adr_i < 6'd42)       fb_q[wb_adr_i] <= wb_dat_i[3:0];
               else if (wb_adr_i == 6'd63) enable_q       <= wb_dat_i[0];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      pwm_d   = pwm_q;
      case (state_q)
         BLANK: begin
            state_d = DRIVE;
            pwm_d   = '0;
         end
         DRIVE: begin
            if (pwm_q == 4'd14) begin
               state_d = BLANK;
               row_d   = (row_q == 3'd6) ? '0 : row_q + 1'b1;
            end else begin
               pwm_d = pwm_q + 1'b1;
            end
         end
         default: state_d = BLANK;
      endcase
   end

   // Pins are computed from the state being entered so outputs line up with it.
   always_comb begin
      en_d  = '0;
      out_d = '0;
      pin   = '0;
      col   = '0;
      idx   = '0;
      if (state_d == DRIVE && enable_q) begin
         en_d[row_d]  = 1'b1;
         out_d[row_d] = 1'b1;
         for (int unsigned p = 0; p < 7; p++) begin
            pin = 3'(p);
            if (pin != row_d) begin
               col = (pin < row_d) ? pin : pin - 3'd1;
               idx = {3'b0, row_d} * 6'd6 + {3'b0, col};
               if (fb_q[idx] > pwm_d) en_d[pin] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q          <= BLANK;
         row_q            <= '0;
         pwm_q            <= '0;
         charlieplex_en_o <= '0;
         charlieplex_o    <= '0;
      end else if (tick) begin
         state_q          <= state_d;
         row_q            <= row_d;
         pwm_q            <= pwm_d;
         charlieplex_en_o <= en_d;
         charlieplex_o    <= out_d;
      end
   end

endmodule
